// File: rtl/fc_seq_pkg.sv
// fc_seq_pkg: shared definitions for stochastic layer sequencers.
//   - seq_state_e : evaluation window states
//   - DEF_*       : default phase lengths reused by sibling sequencers
//   - cnt_width() : width needed to hold a count of 0..max_val
package fc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FLUSH  = 3'd1,
        ST_WARMUP = 3'd2,
        ST_RUN    = 3'd3,
        ST_UPDATE = 3'd4,
        ST_DONE   = 3'd5
    } seq_state_e;

    localparam int DEF_N          = 25;
    localparam int DEF_STREAM_LEN = 256;
    localparam int DEF_FLUSH_CYC  = 4;
    localparam int DEF_WARM_CYC   = 8;
    localparam int DEF_UPD_CYC    = 2;

    // Bits needed to represent every value 0..max_val (never less than 1).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/fc_bit_counter_bank.sv
// fc_bit_counter_bank: N ones-counters, one per node bitstream, with a
// registered read port.
//   CLK, INIT         : clock, synchronous active-high reset
//   clr               : zero every counter
//   en                : add bits[i] into counter i this cycle
//   bits[N-1:0]       : node bitstreams
//   rd_sel[SW-1:0]    : counter to read; indices >= N read as 0
//   rd_count[CW-1:0]  : selected count, one cycle after rd_sel
module fc_bit_counter_bank
    import fc_seq_pkg::*;
#(
    parameter int N  = 25,
    parameter int CW = 9,
    parameter int SW = 5
) (
    input  logic          CLK,
    input  logic          INIT,
    input  logic          clr,
    input  logic          en,
    input  logic [N-1:0]  bits,
    input  logic [SW-1:0] rd_sel,
    output logic [CW-1:0] rd_count
);

    logic [CW-1:0] count_q [N];
    logic [CW-1:0] count_d [N];
    logic [CW-1:0] rd_count_q;
    logic [CW-1:0] rd_count_d;

    // Next counter values: clear, accumulate one bit, or hold.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            if (clr) begin
                count_d[i] = '0;
            end else if (en) begin
                count_d[i] = count_q[i] + CW'(bits[i]);
            end else begin
                count_d[i] = count_q[i];
            end
        end
    end

    // Read mux built as a compare chain so out-of-range selects fall to 0.
    always_comb begin
        rd_count_d = '0;
        for (int i = 0; i < N; i++) begin
            rd_count_d = (rd_sel == SW'(i)) ? count_q[i] : rd_count_d;
        end
    end

    // Counter and read-port registers.
    always_ff @(posedge CLK) begin
        if (INIT) begin
            for (int i = 0; i < N; i++) begin
                count_q[i] <= '0;
            end
            rd_count_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                count_q[i] <= count_d[i];
            end
            rd_count_q <= rd_count_d;
        end
    end

    assign rd_count = rd_count_q;

endmodule

// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer: runs one stochastic FC layer through flush, warm-up,
// a counted bitstream run and an optional training-update hold, then
// hands per-node ones counts to the host.
//   CLK, INIT            : clock, synchronous active-high reset
//   start/train_mode     : begin evaluation (IDLE only), training request
//   abort                : drop the current evaluation (busy states only)
//   ack                  : host releases results (DONE only)
//   a_out[N-1:0]         : node bitstreams from the layer
//   rd_sel / rd_count    : registered count readback, 1-cycle latency
//   layer_init, train_flag, busy, done, aborted, bit_idx : status/control
module fc_layer_sequencer
    import fc_seq_pkg::*;
#(
    parameter  int N          = DEF_N,
    parameter  int STREAM_LEN = DEF_STREAM_LEN,
    parameter  int FLUSH_CYC  = DEF_FLUSH_CYC,
    parameter  int WARM_CYC   = DEF_WARM_CYC,
    parameter  int UPD_CYC    = DEF_UPD_CYC,
    localparam int CW         = cnt_width(STREAM_LEN),
    localparam int SW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic          CLK,
    input  logic          INIT,
    input  logic          start,
    input  logic          train_mode,
    input  logic          abort,
    input  logic          ack,
    input  logic [N-1:0]  a_out,
    input  logic [SW-1:0] rd_sel,
    output logic          layer_init,
    output logic          train_flag,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [CW-1:0] bit_idx,
    output logic [CW-1:0] rd_count
);

    localparam int PMAX0 = (FLUSH_CYC > WARM_CYC) ? FLUSH_CYC : WARM_CYC;
    localparam int PMAX  = (PMAX0 > UPD_CYC) ? PMAX0 : UPD_CYC;
    localparam int PW    = cnt_width(PMAX);

    seq_state_e    state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [CW-1:0] bit_idx_q, bit_idx_d;
    logic          train_q, train_d;
    logic          aborted_q, aborted_d;
    logic          cnt_clr_s, cnt_en_s, busy_s;

    // Control outputs decoded straight from the state register.
    always_comb begin
        layer_init = 1'b0;
        train_flag = 1'b0;
        busy_s     = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_IDLE:   layer_init = 1'b1;
            ST_FLUSH:  begin layer_init = 1'b1; busy_s = 1'b1; end
            ST_WARMUP: busy_s = 1'b1;
            ST_RUN:    busy_s = 1'b1;
            ST_UPDATE: begin train_flag = 1'b1; busy_s = 1'b1; end
            ST_DONE:   begin layer_init = 1'b1; done = 1'b1; end
            default:   layer_init = 1'b1;
        endcase
    end

    // Next-state, phase counter, bit index and counter-bank controls.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        train_d   = train_q;
        aborted_d = 1'b0;
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_FLUSH;
                    train_d   = train_mode;
                    bit_idx_d = '0;
                    cnt_clr_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (phase_q == PW'(FLUSH_CYC - 1)) begin
                    state_d = (WARM_CYC == 0) ? ST_RUN : ST_WARMUP;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_WARMUP: begin
                if (phase_q == PW'(WARM_CYC - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_WARMUP;
                end
            end
            ST_RUN: begin
                // Every RUN cycle is counted, including the last one.
                cnt_en_s = 1'b1;
                if (bit_idx_q == CW'(STREAM_LEN - 1)) begin
                    state_d = train_q ? ST_UPDATE : ST_DONE;
                end else begin
                    bit_idx_d = bit_idx_q + CW'(1);
                end
            end
            ST_UPDATE: begin
                if (phase_q == PW'(UPD_CYC - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_UPDATE;
                end
            end
            ST_DONE: begin
                // ack wins over start; start is never taken from DONE.
                if (ack) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort beats any phase-end transition; bit_idx keeps its shown value.
        if (busy_s && abort) begin
            state_d   = ST_IDLE;
            bit_idx_d = bit_idx_q;
            aborted_d = 1'b1;
        end else begin
            aborted_d = 1'b0;
        end

        // Shared phase counter: runs only while staying in a timed phase.
        if ((state_d == state_q) &&
            ((state_q == ST_FLUSH) || (state_q == ST_WARMUP) || (state_q == ST_UPDATE))) begin
            phase_d = phase_q + PW'(1);
        end else begin
            phase_d = '0;
        end
    end

    // Sequencer registers.
    always_ff @(posedge CLK) begin
        if (INIT) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            bit_idx_q <= '0;
            train_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_idx_q <= bit_idx_d;
            train_q   <= train_d;
            aborted_q <= aborted_d;
        end
    end

    assign busy    = busy_s;
    assign aborted = aborted_q;
    assign bit_idx = bit_idx_q;

    fc_bit_counter_bank #(
        .N  (N),
        .CW (CW),
        .SW (SW)
    ) u_counters (
        .CLK      (CLK),
        .INIT     (INIT),
        .clr      (cnt_clr_s),
        .en       (cnt_en_s),
        .bits     (a_out),
        .rd_sel   (rd_sel),
        .rd_count (rd_count)
    );

endmodule

// File: tb/tb_fc_layer_sequencer.sv
module tb_fc_layer_sequencer;

    localparam int N  = 4;
    localparam int SL = 16;
    localparam int FC = 2;
    localparam int WC = 3;
    localparam int UC = 2;
    localparam int CW = 5;
    localparam int SW = 2;
    localparam int RUN_FIRST = FC + WC + 1;
    localparam int RUN_LAST  = FC + WC + SL;

    logic          CLK = 1'b0;
    logic          INIT, start, train_mode, abort, ack;
    logic [N-1:0]  a_out;
    logic [SW-1:0] rd_sel;
    logic          layer_init, train_flag, busy, done, aborted;
    logic [CW-1:0] bit_idx, rd_count;

    always #5 CLK = ~CLK;

    fc_layer_sequencer #(
        .N(N), .STREAM_LEN(SL), .FLUSH_CYC(FC), .WARM_CYC(WC), .UPD_CYC(UC)
    ) dut (
        .CLK(CLK), .INIT(INIT), .start(start), .train_mode(train_mode),
        .abort(abort), .ack(ack), .a_out(a_out), .rd_sel(rd_sel),
        .layer_init(layer_init), .train_flag(train_flag), .busy(busy),
        .done(done), .aborted(aborted), .bit_idx(bit_idx), .rd_count(rd_count)
    );

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_e = cycles elapsed since the accepted start (1 = first flush cycle).
    bit m_valid = 1'b0, m_active = 1'b0, m_done = 1'b0, m_train = 1'b0, m_abort = 1'b0;
    int m_e = 0, m_bit = 0, m_rd = 0;
    int m_cnt[N];

    always @(posedge CLK) begin
        if (INIT) begin
            m_valid = 1'b1; m_active = 1'b0; m_done = 1'b0; m_train = 1'b0;
            m_abort = 1'b0; m_e = 0; m_bit = 0; m_rd = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else if (m_valid) begin
            m_rd    = (int'(rd_sel) < N) ? m_cnt[rd_sel] : 0;
            m_abort = 1'b0;
            if (m_active) begin
                if (m_e >= RUN_FIRST && m_e <= RUN_LAST)
                    for (int i = 0; i < N; i++) m_cnt[i] += int'(a_out[i]);
                if (abort) begin
                    m_active = 1'b0; m_abort = 1'b1;
                end else if (m_e == RUN_LAST + (m_train ? UC : 0)) begin
                    m_active = 1'b0; m_done = 1'b1;
                end else begin
                    m_e++;
                end
            end else if (m_done) begin
                if (ack) m_done = 1'b0;
            end else if (start) begin
                m_active = 1'b1; m_e = 1; m_train = train_mode; m_bit = 0;
                for (int i = 0; i < N; i++) m_cnt[i] = 0;
            end
            if (m_active && m_e >= RUN_FIRST && m_e <= RUN_LAST) m_bit = m_e - RUN_FIRST;
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge CLK) begin
        if (m_valid) begin
            check("busy",       busy,       m_active);
            check("done",       done,       m_done);
            check("layer_init", layer_init, !(m_active && m_e > FC));
            check("train_flag", train_flag, m_active && m_train && m_e > RUN_LAST);
            check("aborted",    aborted,    m_abort);
            check("bit_idx",    bit_idx,    m_bit);
            check("rd_count",   rd_count,   m_rd);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Waits (bounded) for done; reports cycles of first layer_init low,
    // first train_flag, done, and the number of train_flag cycles.
    task automatic wait_done(output int fd, output int fl, output int ft, output int nt);
        int cyc;
        cyc = 1; fd = -1; fl = -1; ft = -1; nt = 0;
        while (cyc < 60) begin
            if (!layer_init && fl < 0) fl = cyc;
            if (train_flag) begin
                nt++;
                if (ft < 0) ft = cyc;
            end
            if (done) begin
                fd = cyc;
                break;
            end
            step();
            cyc++;
        end
    endtask

    task automatic read_node(input int idx, input int exp, input string name);
        rd_sel = SW'(idx);
        step();
        check(name, rd_count, exp);
    endtask

    task automatic do_start(input logic tm, input logic [N-1:0] bits);
        a_out = bits; train_mode = tm; start = 1'b1;
        step();
        start = 1'b0; train_mode = 1'b0;
    endtask

    int fd, fl, ft, nt;
    int inf_exp[N] = '{16, 0, 16, 0};
    int lb_exp[N]  = '{0, 0, 1, 0};

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        INIT = 1'b1; start = 1'b0; train_mode = 1'b0; abort = 1'b0; ack = 1'b0;
        a_out = '0; rd_sel = '0;
        step(); step();
        INIT = 1'b0;
        check("rst_layer_init", layer_init, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_train_flag", train_flag, 0);
        check("rst_rd_count", rd_count, 0);
        check("rst_bit_idx", bit_idx, 0);
        step();

        // Inference, constant 0101.
        do_start(1'b0, 4'b0101);
        wait_done(fd, fl, ft, nt);
        check("inf_done_cycle", fd, 22);
        check("inf_first_low", fl, 3);
        check("inf_train_cycles", nt, 0);
        check("inf_bit_idx_hold", bit_idx, SL - 1);
        for (int i = 0; i < N; i++) read_node(i, inf_exp[i], "inf_count");
        ack = 1'b1; step(); ack = 1'b0;

        // Warm-up excluded, final RUN bit counted.
        do_start(1'b0, 4'b1111);
        for (int c = 1; c <= 21; c++) begin
            a_out = (c < RUN_FIRST) ? 4'b1111 : ((c == RUN_LAST) ? 4'b0100 : 4'b0000);
            step();
        end
        a_out = '0;
        check("lb_done", done, 1);
        for (int i = 0; i < N; i++) read_node(i, lb_exp[i], "lb_count");
        ack = 1'b1; step(); ack = 1'b0;

        // Training run.
        do_start(1'b1, 4'b0000);
        wait_done(fd, fl, ft, nt);
        check("trn_done_cycle", fd, 24);
        check("trn_first_flag", ft, 22);
        check("trn_flag_cycles", nt, 2);
        check("trn_busy_at_done", busy, 0);
        ack = 1'b1; step(); ack = 1'b0;

        // Abort at bit_idx 5.
        do_start(1'b0, 4'b0001);
        for (int c = 1; c < 11; c++) step();
        check("abt_bit_idx", bit_idx, 5);
        abort = 1'b1; step(); abort = 1'b0;
        check("abt_pulse", aborted, 1);
        check("abt_busy", busy, 0);
        step();
        check("abt_pulse_end", aborted, 0);
        for (int c = 0; c < 30; c++) begin
            if (done) check("abt_no_done", done, 0);
            step();
        end
        read_node(0, 6, "abt_partial");
        do_start(1'b0, 4'b0000);
        rd_sel = '0; step();
        check("abt_cleared", rd_count, 0);
        abort = 1'b1; step(); abort = 1'b0; step();

        // Reset mid-RUN.
        do_start(1'b0, 4'b1111);
        for (int c = 1; c < 10; c++) step();
        INIT = 1'b1; step(); INIT = 1'b0;
        check("init_layer_init", layer_init, 1);
        check("init_busy", busy, 0);
        for (int i = 0; i < N; i++) read_node(i, 0, "init_count");

        // DONE handshake corner cases.
        do_start(1'b0, 4'b0011);
        wait_done(fd, fl, ft, nt);
        check("dn_done_cycle", fd, 22);
        start = 1'b1; step();
        check("dn_start_ignored", done, 1);
        ack = 1'b1; step(); start = 1'b0; ack = 1'b0;
        check("dn_ack_done", done, 0);
        step();
        check("dn_no_new_run", busy, 0);
        read_node(1, 16, "dn_retained");
        do_start(1'b0, 4'b1000);
        wait_done(fd, fl, ft, nt);
        check("dn_rerun_cycle", fd, 22);
        read_node(3, 16, "dn_rerun_n3");
        read_node(0, 0, "dn_rerun_n0");
        ack = 1'b1; step(); ack = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
